// File: rtl/unsigned_div_pkg.sv
// ============================================================================
// Module      : unsigned_div_pkg
// Description : Shared FSM state type and default widths for the unsigned
//               sequential restoring divider.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package unsigned_div_pkg;

  // Default operand widths
  localparam int DEF_DIVIDEND_W = 12;
  localparam int DEF_DIVISOR_W  = 6;

  // Divider control states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

endpackage : unsigned_div_pkg

`default_nettype wire

// File: rtl/restoring_div_step.sv
// ============================================================================
// Module      : restoring_div_step
// Description : One combinational restoring-division iteration. Shifts the
//               next dividend bit into the partial remainder and conditionally
//               subtracts the divisor, producing one quotient bit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module restoring_div_step #(
  parameter int DIVISOR_W = 6
) (
  input  logic [DIVISOR_W:0]   rem_i,
  input  logic                 bit_i,
  input  logic [DIVISOR_W-1:0] divisor_i,
  output logic [DIVISOR_W:0]   rem_o,
  output logic                 qbit_o
);

  logic [DIVISOR_W:0] w_shift;
  logic [DIVISOR_W:0] w_div_ext;
  logic               w_ge;

  // Shift, compare and conditionally subtract. The bit shifted out of the
  // partial remainder is only ever set for a zero divisor; it still means
  // the true shifted value exceeds the divisor, so it forces a subtract.
  always_comb begin
    w_shift   = {rem_i[DIVISOR_W-1:0], bit_i};
    w_div_ext = {1'b0, divisor_i};
    w_ge      = rem_i[DIVISOR_W] | (w_shift >= w_div_ext);
    rem_o     = w_ge ? (w_shift - w_div_ext) : w_shift;
    qbit_o    = w_ge;
  end

endmodule : restoring_div_step

`default_nettype wire

// File: rtl/unsigned_seq_divider.sv
// ============================================================================
// Module      : unsigned_seq_divider
// Description : Unsigned sequential restoring divider, one quotient bit per
//               clock, MSB first. Result is registered and held until the
//               next completion or reset.
//               Optional macro UNSIGNED_DIV_ZERO_DET_EN adds a div_zero output
//               and finishes a zero-divisor operation after one step.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module unsigned_seq_divider
  import unsigned_div_pkg::*;
#(
  parameter int DIVIDEND_W = DEF_DIVIDEND_W,
  parameter int DIVISOR_W  = DEF_DIVISOR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
`ifdef UNSIGNED_DIV_ZERO_DET_EN
  output logic                  div_zero,
`endif
  output logic                  ready,
  output logic                  done
);

  localparam int CNT_W = $clog2(DIVIDEND_W + 1);
  localparam logic [CNT_W-1:0] c_cnt_load = CNT_W'(DIVIDEND_W);
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(1);

  div_state_e state_q, state_d;

  // Dividend bits shift out at the top while quotient bits shift in below
  logic [DIVIDEND_W-1:0] dq_q;
  logic [DIVISOR_W-1:0]  divisor_q;
  logic [DIVISOR_W:0]    rem_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [DIVIDEND_W-1:0] quotient_q;
  logic [DIVISOR_W-1:0]  remainder_q;

  logic [DIVISOR_W:0]    w_rem_next;
  logic                  w_qbit;
  logic [DIVIDEND_W-1:0] w_dq_next;
  logic                  w_accept;
  logic                  w_last;
  logic                  w_dz;

  restoring_div_step #(
    .DIVISOR_W (DIVISOR_W)
  ) u_step (
    .rem_i     (rem_q),
    .bit_i     (dq_q[DIVIDEND_W-1]),
    .divisor_i (divisor_q),
    .rem_o     (w_rem_next),
    .qbit_o    (w_qbit)
  );

  assign w_dq_next = {dq_q[DIVIDEND_W-2:0], w_qbit};
  assign w_accept  = start & ready;

`ifdef UNSIGNED_DIV_ZERO_DET_EN
  logic div_zero_q;
  assign div_zero = div_zero_q;
  assign w_dz     = (divisor_q == '0);
`else
  assign w_dz     = 1'b0;
`endif

  assign w_last = (cnt_q == c_cnt_last) | w_dz;

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; a start in DONE is accepted back-to-back
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start)  state_d = ST_BUSY;
      ST_BUSY: if (w_last) state_d = ST_DONE;
      ST_DONE: state_d = start ? ST_BUSY : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded from the state
  always_comb begin
    ready = 1'b0;
    done  = 1'b0;
    case (state_q)
      ST_IDLE: ready = 1'b1;
      ST_DONE: begin
        ready = 1'b1;
        done  = 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath: capture on acceptance, iterate while busy, publish at the end
  always_ff @(posedge clk) begin
    if (rst) begin
      dq_q        <= '0;
      divisor_q   <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
`ifdef UNSIGNED_DIV_ZERO_DET_EN
      div_zero_q  <= 1'b0;
`endif
    end else if (w_accept) begin
      dq_q      <= dividend;
      divisor_q <= divisor;
      rem_q     <= '0;
      cnt_q     <= c_cnt_load;
`ifdef UNSIGNED_DIV_ZERO_DET_EN
      div_zero_q <= 1'b0;
`endif
    end else if (state_q == ST_BUSY) begin
      if (w_dz) begin
`ifdef UNSIGNED_DIV_ZERO_DET_EN
        // Zero divisor short-cut: same result the full iteration would give
        cnt_q       <= '0;
        quotient_q  <= '1;
        remainder_q <= dq_q[DIVISOR_W-1:0];
        div_zero_q  <= 1'b1;
`endif
      end else begin
        dq_q  <= w_dq_next;
        rem_q <= w_rem_next;
        cnt_q <= cnt_q - c_cnt_last;
        if (cnt_q == c_cnt_last) begin
          quotient_q  <= w_dq_next;
          remainder_q <= w_rem_next[DIVISOR_W-1:0];
        end
      end
    end
  end

  assign quotient  = quotient_q;
  assign remainder = remainder_q;

endmodule : unsigned_seq_divider

`default_nettype wire

// File: tb/tb_unsigned_seq_divider.sv
// ============================================================================
// Module      : tb_unsigned_seq_divider
// Description : Directed self-checking bench for unsigned_seq_divider.
//               Honours UNSIGNED_DIV_ZERO_DET_EN for the zero-divisor case.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_unsigned_seq_divider;

  logic        clk;
  logic        rst;
  logic        start;
  logic [11:0] dividend;
  logic [5:0]  divisor;
  logic [11:0] quotient;
  logic [5:0]  remainder;
  logic        ready;
  logic        done;
`ifdef UNSIGNED_DIV_ZERO_DET_EN
  logic        div_zero;
`endif

  int checks = 0;
  int errors = 0;
  int e;
  int seen;

  unsigned_seq_divider #(
    .DIVIDEND_W (12),
    .DIVISOR_W  (6)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .quotient  (quotient),
    .remainder (remainder),
`ifdef UNSIGNED_DIV_ZERO_DET_EN
    .div_zero  (div_zero),
`endif
    .ready     (ready),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Present operands and a one-cycle start; returns just after E0
  task automatic do_start(input logic [11:0] a, input logic [5:0] b);
    @(negedge clk);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(negedge clk);
    start    = 1'b0;
  endtask

  // Advance until done is seen; eo is the index of the last edge passed
  task automatic wait_done(input int ei, output int eo);
    eo = ei;
    while (!done && eo < 40) begin
      @(negedge clk);
      eo++;
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_ready", ready, 1);
    chk("rst_done", done, 0);
    chk("rst_quot", quotient, 0);
    chk("rst_rem", remainder, 0);

    // 100 / 7
    do_start(12'd100, 6'd7);
    chk("busy_ready", ready, 0);
    wait_done(0, e);
    chk("lat_100_7", e, 12);
    chk("q_100_7", quotient, 14);
    chk("r_100_7", remainder, 2);
    @(negedge clk);
    chk("done_pulse", done, 0);
    chk("idle_ready", ready, 1);
    chk("hold_q", quotient, 14);

    // 4095 / 1
    do_start(12'd4095, 6'd1);
    wait_done(0, e);
    chk("q_4095_1", quotient, 4095);
    chk("r_4095_1", remainder, 0);

    // 5 / 63
    do_start(12'd5, 6'd63);
    wait_done(0, e);
    chk("q_5_63", quotient, 0);
    chk("r_5_63", remainder, 5);

    // 0xABC / 0
    do_start(12'hABC, 6'd0);
    wait_done(0, e);
`ifdef UNSIGNED_DIV_ZERO_DET_EN
    chk("lat_div0", e, 1);
    chk("div_zero_set", div_zero, 1);
`else
    chk("lat_div0", e, 12);
`endif
    chk("q_div0", quotient, 12'hFFF);
    chk("r_div0", remainder, 6'h3C);

    // start at E5 while busy is ignored
    do_start(12'd100, 6'd7);
    repeat (4) @(negedge clk);
    start = 1'b1; dividend = 12'd200; divisor = 6'd9;
    @(negedge clk);
    start = 1'b0;
    wait_done(5, e);
    chk("lat_ignore", e, 12);
    chk("q_ignore", quotient, 14);
    chk("r_ignore", remainder, 2);
`ifdef UNSIGNED_DIV_ZERO_DET_EN
    chk("div_zero_clr", div_zero, 0);
`endif

    // reset at E6 aborts
    do_start(12'd1000, 6'd13);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_ready", ready, 1);
    chk("abort_done", done, 0);
    chk("abort_quot", quotient, 0);
    chk("abort_rem", remainder, 0);
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) seen++;
    end
    chk("abort_no_done", seen, 0);

    // back-to-back: 1000/13 then 200/9 accepted in the DONE cycle
    do_start(12'd1000, 6'd13);
    wait_done(0, e);
    chk("q_1000_13", quotient, 76);
    chk("r_1000_13", remainder, 12);
    start = 1'b1; dividend = 12'd200; divisor = 6'd9;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_busy", ready, 0);
    wait_done(0, e);
    chk("lat_b2b", e, 12);
    chk("q_200_9", quotient, 22);
    chk("r_200_9", remainder, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_unsigned_seq_divider

`default_nettype wire
